rr_grant_arbiter: RTL and testbench
===================================

# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource among 32 requesters. It uses a 32-bit LSB-first priority encoder for index selection and adds rotating priority, grant locking, and a hold-time limit. It sits between the requester bank and the shared resource, and its registered one-hot grant drives the resource's input mux.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one grant may be held. 0 means unlimited.
- HOLD_W, default $clog2(MAX_HOLD+1): derived width of the hold counter. Not overridden.
- clk_i  input  1  single clock, rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- req_i  input  32  per-requester request level; bit n is requester n.
- gnt_o  output  32  registered one-hot grant; all zero when idle.
- gnt_idx_o  output  5  binary index of the granted requester; valid only while gnt_valid_o = 1.
- gnt_valid_o  output  1  high while a grant is held; equals |gnt_o.
- preempt_o  output  1  one-cycle pulse when a grant ends because MAX_HOLD expired.

## Operation
- States: IDLE, GRANT. Register ptr[4:0] is the highest-priority index for the next arbitration.
- IDLE behaviour:
  - mask = req_i & ~((32'b1 << ptr) - 1), so only indices ≥ ptr are kept.
  - If mask ≠ 0, winner = lowest set index of mask. Otherwise, if req_i ≠ 0, winner = lowest set index of req_i. Otherwise stay in IDLE.
  - On a winner: gnt_o <= 1 << winner, gnt_idx_o <= winner, gnt_valid_o <= 1, hold_cnt <= 0, state <= GRANT.
- GRANT behaviour:
  - The grant stays locked while req_i[gnt_idx_o] = 1 and the hold limit has not been reached. hold_cnt increments each cycle and saturates.
  - Release (req_i[gnt_idx_o] = 0) or expiry (MAX_HOLD ≠ 0 and hold_cnt = MAX_HOLD-1 with the request still high) causes:
    - gnt_o <= 0, gnt_valid_o <= 0, gnt_idx_o held.
    - ptr <= gnt_idx_o + 1, with natural 5-bit wrap so 31 goes to 0.
    - state <= IDLE.
  - preempt_o <= 1 for one cycle on expiry only.
- When release and expiry coincide in the same cycle, it is treated as a release: no preempt pulse.
- Requests are level-sensitive and never latched. A request that drops before it is sampled in IDLE is never granted.
- Other requests changing during GRANT do not affect the current grant.

## Timing
- Reset values:
  - gnt_o = 0, gnt_idx_o = 0, gnt_valid_o = 0, preempt_o = 0.
  - ptr = 0, hold_cnt = 0, state = IDLE.
- Reset asserted mid-grant: all outputs are at reset values after the next rising edge. No preempt pulse is produced.
- Arbitration latency: req_i sampled in IDLE at edge t gives gnt_o valid after edge t (visible in cycle t+1).
- Release latency: req_i[idx] low sampled at edge t gives gnt_o = 0 after edge t.
- There is always at least one IDLE cycle between consecutive grants. Maximum grant rate is one per 2 cycles.
- Maximum hold with MAX_HOLD = M ≠ 0: gnt_o is high for exactly M cycles.
- All outputs are registered. There is no combinational path from req_i to any output.

## Structure
- Shared package arb_pkg holds:
  - typedef arb_state_e {IDLE, GRANT}
  - localparam N_REQ = 32, IDX_W = 5
- Sub-module priority_encoder, instantiated twice:
  - one on mask (data_o gives the index, valid_o gives mask ≠ 0);
  - one on raw req_i.
- Its valid_o is not trusted for bit 0. Validity is computed as |mask and |req_i in this block.
- The winner mux, ptr, hold counter and FSM live in rr_grant_arbiter.

## Test plan
- Reset, then req_i = 32'h0000_0000 for 10 cycles -> gnt_valid_o = 0 and gnt_o = 0 throughout. Assert rst_ni = 0 during a grant -> outputs are 0 after one edge.
- req_i = 32'h0000_0011 constant, each holder drops its request for 1 cycle after 3 granted cycles -> grant sequence 0, 4, 0, 4 with gnt_idx_o = 0, 4, 0, 4 and ptr = 1, 5, 1, 5.
- ptr = 31 (reached by granting 30 and releasing), req_i = 32'h8000_0001 -> grant 31 first. After release, ptr wraps to 0 and grant 0 follows.
- MAX_HOLD = 16, req_i[7] held high continuously, no other requests -> gnt_o[7] high exactly 16 cycles, preempt_o pulses once, 1 idle cycle, then re-grant to 7.
- req_i = 32'h0000_0008 for exactly 1 cycle while in GRANT for requester 2 -> requester 3 is never granted.
- Requester 5 releases on the exact expiry cycle (MAX_HOLD = 4, req_i[5] drops in the 4th grant cycle) -> preempt_o stays 0 and ptr = 6.

Source files
------------

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin grant arbiter.
//   N_REQ       : number of requesters sharing the downstream resource
//   IDX_W       : width of a binary requester index
//   arb_state_e : arbiter FSM state (IDLE waits for requests, GRANT holds one)
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_grant_arbiter_priority_encoder.sv
// ---------------------------------------------------------------------------
// priority_encoder
// LSB-first priority encoder: reports the lowest set bit of data_i.
//   data_i  : input  [N_REQ-1:0]  vector to encode
//   data_o  : output [IDX_W-1:0]  index of the lowest set bit (0 if none)
//   valid_o : output              high when any bit of data_i is set
// ---------------------------------------------------------------------------
module priority_encoder
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] data_i,
  output logic [IDX_W-1:0] data_o,
  output logic             valid_o
);

  // Scan from the top down so the last hit written is the lowest set index.
  always_comb begin
    data_o  = '0;
    valid_o = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (data_i[i]) begin
        data_o  = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter sharing one downstream resource among 32 requesters,
// with rotating priority, grant locking and an optional hold-time limit.
//   clk_i       : input        clock, rising edge
//   rst_ni      : input        synchronous active-low reset
//   req_i       : input  [31:0] request levels, bit n = requester n
//   gnt_o       : output [31:0] registered one-hot grant, zero when idle
//   gnt_idx_o   : output [4:0]  binary index of the granted requester
//   gnt_valid_o : output        high while a grant is held
//   preempt_o   : output        one-cycle pulse when MAX_HOLD ends a grant
// Parameters:
//   MAX_HOLD    : longest grant in cycles, 0 = unlimited
//   HOLD_W      : hold counter width, derived from MAX_HOLD
// ---------------------------------------------------------------------------
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             preempt_o
);

  // MAX_HOLD = 0 would give a zero-width counter, so keep at least one bit.
  localparam int CNT_W = (HOLD_W < 1) ? 1 : HOLD_W;
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_holdCnt;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gntIdx;
  logic             r_gntValid;
  logic             r_preempt;

  logic [N_REQ-1:0] w_mask;
  logic [IDX_W-1:0] w_maskIdx;
  logic [IDX_W-1:0] w_reqIdx;
  logic             w_maskEncValid;
  logic             w_reqEncValid;
  logic             w_unusedEncValid;
  logic             w_maskAny;
  logic             w_reqAny;
  logic [IDX_W-1:0] w_winner;
  logic             w_heldReq;
  logic             w_expire;

  // Keep only requesters at or above the rotating pointer.
  assign w_mask = req_i & ~((N_REQ'(1) << r_ptr) - N_REQ'(1));

  priority_encoder u_maskEnc (
    .data_i  (w_mask),
    .data_o  (w_maskIdx),
    .valid_o (w_maskEncValid)
  );

  priority_encoder u_reqEnc (
    .data_i  (req_i),
    .data_o  (w_reqIdx),
    .valid_o (w_reqEncValid)
  );

  // Encoder valid flags are not relied on; presence is reduced locally.
  assign w_unusedEncValid = w_maskEncValid ^ w_reqEncValid;
  assign w_maskAny        = |w_mask;
  assign w_reqAny         = |req_i;

  // Wrap around to the lowest requester when nobody sits at or above ptr.
  assign w_winner  = w_maskAny ? w_maskIdx : w_reqIdx;

  assign w_heldReq = req_i[r_gntIdx];
  assign w_expire  = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LAST);

  // Arbitration FSM. Release is tested before expiry, so a request that
  // drops on the final allowed cycle ends the grant without a preempt.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_holdCnt  <= '0;
      r_gnt      <= '0;
      r_gntIdx   <= '0;
      r_gntValid <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_reqAny) begin
            r_gnt      <= N_REQ'(1) << w_winner;
            r_gntIdx   <= w_winner;
            r_gntValid <= 1'b1;
            r_holdCnt  <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (!w_heldReq || w_expire) begin
            r_gnt      <= '0;
            r_gntValid <= 1'b0;
            r_ptr      <= r_gntIdx + IDX_W'(1);
            r_state    <= IDLE;
            // Reaching here with the request still high means expiry.
            r_preempt  <= w_heldReq;
          end else if (r_holdCnt != {CNT_W{1'b1}}) begin
            r_holdCnt <= r_holdCnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_gntIdx;
  assign gnt_valid_o = r_gntValid;
  assign preempt_o   = r_preempt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Drives two arbiters (MAX_HOLD 16 and 4) with the same request stream and
// checks both against a behavioural round-robin model every cycle, plus
// hand-computed expectations at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter;

  logic        clk;
  logic        rst_ni;
  logic [31:0] req_i;

  logic [31:0] gnt16, gnt4;
  logic [4:0]  idx16, idx4;
  logic        vld16, vld4;
  logic        pre16, pre4;

  int errors = 0;
  int checks = 0;
  logic checkEn = 1'b0;

  rr_grant_arbiter #(.MAX_HOLD(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt16),
    .gnt_idx_o   (idx16),
    .gnt_valid_o (vld16),
    .preempt_o   (pre16)
  );

  rr_grant_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt4),
    .gnt_idx_o   (idx4),
    .gnt_valid_o (vld4),
    .preempt_o   (pre4)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: granted flag, who holds it, how many cycles it has
  // been visible, the next starting point for the circular search, and
  // whether the last grant ended by timing out.
  typedef struct packed {
    logic       grant;
    logic [4:0] ptr;
    logic [4:0] idx;
    int         held;
    logic       pre;
  } mdl_t;

  mdl_t m16, m4;

  function automatic mdl_t step(mdl_t s, logic [31:0] req, logic rst, int m);
    mdl_t n;
    bit   found;
    int   cand;
    if (!rst) begin
      n = '0;
      return n;
    end
    n     = s;
    n.pre = 1'b0;
    found = 1'b0;
    if (!s.grant) begin
      for (int k = 0; k < 32; k++) begin
        cand = (int'(s.ptr) + k) % 32;
        if (!found && req[cand]) begin
          found   = 1'b1;
          n.grant = 1'b1;
          n.idx   = 5'(cand);
          n.held  = 1;
        end
      end
    end else if (!req[s.idx]) begin
      n.grant = 1'b0;
      n.ptr   = 5'((int'(s.idx) + 1) % 32);
    end else if (m != 0 && s.held == m) begin
      n.grant = 1'b0;
      n.ptr   = 5'((int'(s.idx) + 1) % 32);
      n.pre   = 1'b1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  // Advance both models on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    m16 <= step(m16, req_i, rst_ni, 16);
    m4  <= step(m4, req_i, rst_ni, 4);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] oneHot(mdl_t s);
    return s.grant ? (32'h1 << s.idx) : 32'h0;
  endfunction

  // Every-cycle comparison of both DUTs against the model, away from the
  // active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m16 gnt",   gnt16,        oneHot(m16));
      checkOutput("m16 valid", 32'(vld16),   32'(m16.grant));
      checkOutput("m16 idx",   32'(idx16),   32'(m16.idx));
      checkOutput("m16 pre",   32'(pre16),   32'(m16.pre));
      checkOutput("m4 gnt",    gnt4,         oneHot(m4));
      checkOutput("m4 valid",  32'(vld4),    32'(m4.grant));
      checkOutput("m4 idx",    32'(idx4),    32'(m4.idx));
      checkOutput("m4 pre",    32'(pre4),    32'(m4.pre));
    end
  end

  // Drive a request pattern at a falling edge and hold it for n cycles.
  task automatic applyStimulus(input logic [31:0] value, input int n);
    req_i = value;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = 32'h0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset gnt",   gnt16,        32'h0);
    checkOutput("reset idx",   32'(idx16),   32'h0);
    checkOutput("reset valid", 32'(vld16),   32'h0);
    rst_ni = 1'b1;

    // Idle with no requests.
    $display("[TB] idle with no requests");
    applyStimulus(32'h0, 10);
    checkOutput("idle gnt",   gnt16,      32'h0);
    checkOutput("idle valid", 32'(vld16), 32'h0);

    // Alternation between requesters 0 and 4.
    $display("[TB] alternation 0/4");
    applyStimulus(32'h11, 1);
    checkOutput("alt first 0", gnt16, 32'h1);
    applyStimulus(32'h11, 2);
    applyStimulus(32'h10, 1);
    checkOutput("alt gap 1", gnt16, 32'h0);
    applyStimulus(32'h11, 1);
    checkOutput("alt then 4", gnt16, 32'h10);
    checkOutput("alt idx 4", 32'(idx16), 32'd4);
    applyStimulus(32'h11, 2);
    applyStimulus(32'h01, 1);
    checkOutput("alt gap 2", gnt16, 32'h0);
    applyStimulus(32'h11, 1);
    checkOutput("alt wrap 0", gnt16, 32'h1);
    applyStimulus(32'h11, 2);
    applyStimulus(32'h10, 1);
    applyStimulus(32'h11, 1);
    checkOutput("alt again 4", gnt16, 32'h10);
    applyStimulus(32'h0, 2);

    // Pointer reaches 31 and wraps to 0.
    $display("[TB] pointer wrap");
    applyStimulus(32'h4000_0000, 1);
    checkOutput("wrap idx 30", 32'(idx16), 32'd30);
    applyStimulus(32'h0, 1);
    applyStimulus(32'h8000_0001, 1);
    checkOutput("wrap gnt 31", gnt16, 32'h8000_0000);
    checkOutput("wrap idx 31", 32'(idx16), 32'd31);
    applyStimulus(32'h1, 1);
    checkOutput("wrap release", gnt16, 32'h0);
    applyStimulus(32'h1, 1);
    checkOutput("wrap gnt 0", gnt16, 32'h1);
    applyStimulus(32'h0, 1);

    // A one-cycle request during another grant is never served.
    $display("[TB] short request during grant");
    applyStimulus(32'h4, 1);
    checkOutput("short gnt 2", gnt16, 32'h4);
    applyStimulus(32'hC, 1);
    checkOutput("short locked", gnt16, 32'h4);
    applyStimulus(32'h4, 1);
    applyStimulus(32'h0, 4);
    checkOutput("short never 3", gnt16, 32'h0);

    // Hold limit of 16 on requester 7.
    $display("[TB] hold limit");
    applyStimulus(32'h80, 1);
    checkOutput("hold first", gnt16, 32'h80);
    applyStimulus(32'h80, 15);
    checkOutput("hold cycle 16", gnt16, 32'h80);
    checkOutput("hold no pre", 32'(pre16), 32'h0);
    applyStimulus(32'h80, 1);
    checkOutput("hold expired", gnt16, 32'h0);
    checkOutput("hold preempt", 32'(pre16), 32'h1);
    applyStimulus(32'h80, 1);
    checkOutput("hold regrant", gnt16, 32'h80);
    checkOutput("hold pre done", 32'(pre16), 32'h0);
    applyStimulus(32'h0, 2);

    // Release on the exact expiry cycle of the MAX_HOLD=4 arbiter.
    $display("[TB] release at expiry");
    applyStimulus(32'h20, 1);
    checkOutput("coin gnt 5", gnt4, 32'h20);
    applyStimulus(32'h20, 3);
    checkOutput("coin cycle 4", gnt4, 32'h20);
    applyStimulus(32'h0, 1);
    checkOutput("coin released", gnt4, 32'h0);
    checkOutput("coin no pre", 32'(pre4), 32'h0);
    applyStimulus(32'h41, 1);
    checkOutput("coin ptr 6", 32'(idx4), 32'd6);

    // Reset in the middle of a grant.
    $display("[TB] reset mid-grant");
    rst_ni = 1'b0;
    @(negedge clk);
    checkOutput("mid rst gnt",   gnt16,      32'h0);
    checkOutput("mid rst valid", 32'(vld16), 32'h0);
    checkOutput("mid rst idx",   32'(idx16), 32'h0);
    checkOutput("mid rst pre4",  32'(pre4),  32'h0);
    checkOutput("mid rst gnt4",  gnt4,       32'h0);
    rst_ni = 1'b1;
    applyStimulus(32'h0, 3);
    checkOutput("post rst idle", gnt16, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
